gate_truth_checker: RTL and testbench

Synthesizable self-test engine for the two-input gate library: drives every input combination into a gate under test, samples the gate output after a settle interval and compares it against an expected truth table. It is the hardware counterpart of the gate testbenches: it produces the `a`/`b` stimulus, consumes `o`, and reports a verdict. It sits beside any two-input gate instance (`and_*`, `or_*`, `xor_*`, …) for on-chip or FPGA bring-up checks.

---
 rtl/gate_pkg.sv | 22 ++
 rtl/gate_settle_cnt.sv | 32 +++
 rtl/gate_truth_checker.sv | 163 ++++++++++++++++
 tb/tb_gate_truth_checker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the two-input gate self-test engine:
// sweep FSM states, reference truth tables and the vector width.
`timescale 1ns/1ps

package gate_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Truth tables indexed by {b,a}.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

    localparam int VEC_W = 2;

endpackage

// File: rtl/gate_settle_cnt.sv
// Settle-interval counter: counts up while enabled, clears on demand and
// flags the cycle in which the count reaches SETTLE-1.
`timescale 1ns/1ps

module gate_settle_cnt #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [3:0] TC_VAL = 4'(SETTLE - 1);

    logic [3:0] r_cnt;

    // Count settle cycles; clear has priority over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/gate_truth_checker.sv
// Self-test engine for a two-input gate: sweeps {b,a} = 00,01,10,11, holds
// each vector SETTLE+1 cycles, samples the gate output on the last edge and
// compares it with EXP_TT. Reports pass, mismatch count and a done pulse.
// Optional macro GATE_CHK_FIRST_FAIL_EN adds the fail_vec port, which holds
// the first mismatching vector of the last sweep.
`timescale 1ns/1ps

module gate_truth_checker
    import gate_pkg::*;
#(
    parameter logic [3:0] EXP_TT = 4'b1000,
    parameter int         SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    input  logic       o_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt
`ifdef GATE_CHK_FIRST_FAIL_EN
    ,
    output logic [1:0] fail_vec
`endif
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [VEC_W-1:0]   r_vec;
    logic [VEC_W-1:0]   w_vec_nxt;
    logic [VEC_W-1:0]   w_vec_inc;
    logic               r_a;
    logic               w_a_nxt;
    logic               r_b;
    logic               w_b_nxt;
    logic               r_pass;
    logic               w_pass_nxt;
    logic [2:0]         r_err;
    logic [2:0]         w_err_nxt;
    logic [2:0]         w_err_inc;
    logic               w_mismatch;
    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic               w_cnt_tc;

    gate_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_tc  (w_cnt_tc)
    );

    assign w_vec_inc  = r_vec + 2'd1;
    assign w_mismatch = (o_i != EXP_TT[r_vec]);
    // Four vectors can mismatch at most; hold at 4 regardless.
    assign w_err_inc  = (r_err == 3'd4) ? r_err : (r_err + 3'd1);

    // State and sweep datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_pass  <= w_pass_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state, stimulus update and scoreboard for the sweep.
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_pass_nxt  = r_pass;
        w_err_nxt   = r_err;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_vec_nxt   = '0;
                    w_a_nxt     = 1'b0;
                    w_b_nxt     = 1'b0;
                    w_err_nxt   = 3'd0;
                    w_pass_nxt  = 1'b0;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                w_cnt_en = 1'b1;
                if (w_cnt_tc) begin
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                w_cnt_clr = 1'b1;
                if (w_mismatch) begin
                    w_err_nxt = w_err_inc;
                end
                if (r_vec == 2'd3) begin
                    // Verdict is ready on entry to FINISH so it is valid with done.
                    w_pass_nxt  = (r_err == 3'd0) && !w_mismatch;
                    w_state_nxt = FINISH;
                end else begin
                    w_vec_nxt   = w_vec_inc;
                    w_a_nxt     = w_vec_inc[0];
                    w_b_nxt     = w_vec_inc[1];
                    w_state_nxt = DRIVE;
                end
            end
            FINISH: begin
                w_a_nxt     = 1'b0;
                w_b_nxt     = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef GATE_CHK_FIRST_FAIL_EN
    logic [VEC_W-1:0] r_fail_vec;

    // Capture the vector of the first mismatch; err_cnt==0 marks "first".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_vec <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_fail_vec <= '0;
        end else if ((r_state == SAMPLE) && w_mismatch && (r_err == 3'd0)) begin
            r_fail_vec <= r_vec;
        end
    end

    assign fail_vec = r_fail_vec;
`endif

    assign a_o     = r_a;
    assign b_o     = r_b;
    assign busy    = (r_state != IDLE);
    assign done    = (r_state == FINISH);
    assign pass    = r_pass;
    assign err_cnt = r_err;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench for gate_truth_checker: stimulus queues expected sweep
// results, a monitor pops and compares them whenever done pulses.
`timescale 1ns/1ps

module tb_gate_truth_checker;
    import gate_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start0, start1;
    logic       a0, b0, o0, busy0, done0, pass0;
    logic       a1, b1, o1, busy1, done1, pass1;
    logic [2:0] err0, err1;
`ifdef GATE_CHK_FIRST_FAIL_EN
    logic [1:0] fv0, fv1;
`endif
    int         gsel;

    // Gate under test for DUT0: 0 AND, 1 OR, 2 tied high, 3 NAND.
    always_comb begin
        case (gsel)
            0:       o0 = a0 & b0;
            1:       o0 = a0 | b0;
            2:       o0 = 1'b1;
            default: o0 = ~(a0 & b0);
        endcase
    end
    assign o1 = a1 ^ b1;

    gate_truth_checker #(.EXP_TT(TT_AND), .SETTLE(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a_o(a0), .b_o(b0), .o_i(o0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0)
`ifdef GATE_CHK_FIRST_FAIL_EN
        , .fail_vec(fv0)
`endif
    );

    gate_truth_checker #(.EXP_TT(TT_XOR), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_o(a1), .b_o(b1), .o_i(o1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef GATE_CHK_FIRST_FAIL_EN
        , .fail_vec(fv1)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         dut;
        int         done_cyc;
        logic       pass;
        logic [2:0] err;
        logic [1:0] fv;
        logic [31:0] seq;
        int         len;
    } rec_t;

    rec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected {b,a} seen each cycle of a sweep: each vector held settle+1 cycles.
    task automatic expect_sweep(input int dut, input int t0, input int settle,
                                input logic p, input logic [2:0] e, input logic [1:0] fv);
        rec_t r;
        int   idx;
        logic [1:0] v;
        r.dut      = dut;
        r.done_cyc = t0 + 4 * (settle + 1) + 1;
        r.pass     = p;
        r.err      = e;
        r.fv       = fv;
        r.seq      = '0;
        idx        = 0;
        for (int k = 0; k < 4; k++) begin
            v = 2'(k);
            for (int j = 0; j <= settle; j++) begin
                r.seq[2*idx +: 2] = v;
                idx++;
            end
        end
        r.len = idx;
        sb.push_back(r);
    endtask

    // Monitor: collect stimulus while busy, score on every done pulse.
    logic [31:0] obs_seq[2];
    int          obs_len[2];
    initial begin
        rec_t r;
        logic bsy, dn, ps;
        logic [1:0] ab;
        logic [2:0] ec;
        logic [1:0] fvx;
        obs_seq[0] = '0; obs_seq[1] = '0;
        obs_len[0] = 0;  obs_len[1] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                obs_seq[0] = '0; obs_seq[1] = '0;
                obs_len[0] = 0;  obs_len[1] = 0;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    bsy = (d == 0) ? busy0 : busy1;
                    dn  = (d == 0) ? done0 : done1;
                    ps  = (d == 0) ? pass0 : pass1;
                    ab  = (d == 0) ? {b0, a0} : {b1, a1};
                    ec  = (d == 0) ? err0 : err1;
`ifdef GATE_CHK_FIRST_FAIL_EN
                    fvx = (d == 0) ? fv0 : fv1;
`else
                    fvx = 2'b00;
`endif
                    if (bsy && !dn) begin
                        if (obs_len[d] < 16) obs_seq[d][2*obs_len[d] +: 2] = ab;
                        obs_len[d]++;
                    end
                    if (dn) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_done", d, -1);
                        end else begin
                            r = sb.pop_front();
                            chk("dut_id", d, r.dut);
                            chk("done_cycle", cyc + 1, r.done_cyc);
                            chk("pass", int'(ps), int'(r.pass));
                            chk("err_cnt", int'(ec), int'(r.err));
`ifdef GATE_CHK_FIRST_FAIL_EN
                            chk("fail_vec", int'(fvx), int'(r.fv));
`endif
                            chk("stim_len", obs_len[d], r.len);
                            chk("stim_seq", int'(obs_seq[d]), int'(r.seq));
                        end
                        obs_seq[d] = '0;
                        obs_len[d] = 0;
                    end
                end
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    // Single sweep on DUT0 with the chosen gate, then check results are held.
    task automatic sweep0(input int g, input logic p, input logic [2:0] e, input logic [1:0] fv);
        int t0;
        @(negedge clk);
        gsel   = g;
        start0 = 1'b1;
        t0     = cyc + 1;
        expect_sweep(0, t0, 2, p, e, fv);
        @(negedge clk);
        start0 = 1'b0;
        wait_drain();
        repeat (2) @(negedge clk);
        chk("pass_held", int'(pass0), int'(p));
        chk("err_held", int'(err0), int'(e));
        chk("idle_busy", int'(busy0), 0);
        chk("idle_ab", int'({b0, a0}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        gsel   = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_pass", int'(pass0), 0);
        chk("rst_err", int'(err0), 0);
        chk("rst_ab", int'({b0, a0}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        sweep0(0, 1'b1, 3'd0, 2'b00);   // good AND
        sweep0(1, 1'b0, 3'd2, 2'b01);   // OR: vectors 01,10 mismatch
        sweep0(2, 1'b0, 3'd3, 2'b00);   // tied high: 00,01,10 mismatch
        sweep0(3, 1'b0, 3'd4, 2'b00);   // NAND: all four mismatch

        // start held: second sweep accepted on the edge after the done cycle
        @(negedge clk);
        gsel   = 0;
        start0 = 1'b1;
        t0     = cyc + 1;
        expect_sweep(0, t0, 2, 1'b1, 3'd0, 2'b00);
        expect_sweep(0, t0 + 14, 2, 1'b1, 3'd0, 2'b00);
        repeat (15) @(negedge clk);
        start0 = 1'b0;
        wait_drain();

        // reset during vector 2 of an OR sweep (one mismatch already counted)
        @(negedge clk);
        gsel   = 1;
        start0 = 1'b1;
        t0     = cyc + 1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_ab", int'({b0, a0}), 2);
        chk("pre_rst_err", int'(err0), 1);
`ifdef GATE_CHK_FIRST_FAIL_EN
        chk("pre_rst_fv", int'(fv0), 1);
`endif
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ab", int'({b0, a0}), 0);
        chk("mid_rst_busy", int'(busy0), 0);
        chk("mid_rst_done", int'(done0), 0);
        chk("mid_rst_pass", int'(pass0), 0);
        chk("mid_rst_err", int'(err0), 0);
`ifdef GATE_CHK_FIRST_FAIL_EN
        chk("mid_rst_fv", int'(fv0), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        sweep0(0, 1'b1, 3'd0, 2'b00);

        // SETTLE = 1 with XOR gate
        @(negedge clk);
        start1 = 1'b1;
        t0     = cyc + 1;
        expect_sweep(1, t0, 1, 1'b1, 3'd0, 2'b00);
        @(negedge clk);
        start1 = 1'b0;
        wait_drain();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
